adsr_env: RTL and testbench

- Envelope generator directly downstream of the SPI config receiver.
- Consumes adsr_ai, adsr_di, adsr_s, adsr_ri, trig and progn, and produces an 8-bit envelope level that scales the oscillator/filter path.
- Runs a 5-state ADSR machine on a prescaled tick derived from the main clock.
- Mutes to zero while the configuration is being programmed (progn low).

---
 rtl/adsr_pkg.sv | 15 +
 rtl/adsr_tick.sv | 32 +++
 rtl/adsr_env.sv | 145 ++++++++++++++
 tb/tb_adsr_env.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/adsr_pkg.sv
// Shared types and constants for the ADSR envelope generator.
package adsr_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAttack  = 3'd1,
        StDecay   = 3'd2,
        StSustain = 3'd3,
        StRelease = 3'd4
    } adsr_state_e;

    localparam int unsigned ACC_W_DEF = 16;
    localparam logic [15:0] ACC_MAX   = 16'hFFFF;

endpackage

// File: rtl/adsr_tick.sv
// Envelope-rate prescaler: one-cycle tick every PRESCALE main-clock cycles.
module adsr_tick #(
    parameter int unsigned PRESCALE = 512
) (
    input  logic clk,
    input  logic arstn,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CntMax = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        tick  = (cnt_q == CntMax);
        cnt_d = cnt_q + CW'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

endmodule

// File: rtl/adsr_env.sv
// ADSR envelope generator; muted and held in IDLE while configuration is programmed.
module adsr_env
    import adsr_pkg::*;
#(
    parameter int unsigned PRESCALE = 512,
    parameter int unsigned ACC_W    = ACC_W_DEF
) (
    input  logic       clk,
    input  logic       arstn,
    input  logic [7:0] adsr_ai,
    input  logic [7:0] adsr_di,
    input  logic [7:0] adsr_s,
    input  logic [7:0] adsr_ri,
    input  logic       trig,
    input  logic       progn,
    output logic [7:0] env,
    output logic       active
);

    localparam int unsigned AW1 = ACC_W + 1;
    localparam logic [ACC_W-1:0] AccMax = {ACC_W{1'b1}};

    logic        progn_meta_q, progn_sync_q;
    logic        clear, tick;

    adsr_state_e      state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] s_tgt;
    logic [ACC_W:0]   att_sum, dec_diff, rel_diff;
    logic             att_done, dec_done, rel_done;

    // Reset value 0 keeps the envelope muted until programming is known finished.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            progn_meta_q <= 1'b0;
            progn_sync_q <= 1'b0;
        end else begin
            progn_meta_q <= progn;
            progn_sync_q <= progn_meta_q;
        end
    end

    assign clear = ~progn_sync_q;

    adsr_tick #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk   (clk),
        .arstn (arstn),
        .clear (clear),
        .tick  (tick)
    );

    // Extra headroom bit so neither the add nor the subtracts can wrap.
    always_comb begin
        s_tgt    = {adsr_s, {(ACC_W-8){1'b0}}};
        att_sum  = {1'b0, acc_q} + AW1'(adsr_ai);
        dec_diff = {1'b0, acc_q} - AW1'(adsr_di);
        rel_diff = {1'b0, acc_q} - AW1'(adsr_ri);
        att_done = (adsr_ai == 8'd0) || (att_sum >= {1'b0, AccMax});
        dec_done = (adsr_di == 8'd0) || dec_diff[ACC_W] || (dec_diff <= {1'b0, s_tgt});
        rel_done = (adsr_ri == 8'd0) || ({1'b0, acc_q} <= AW1'(adsr_ri));
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q <= StIdle;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end

    // Gate changes are checked before the completion/arithmetic conditions.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        if (clear) begin
            state_d = StIdle;
            acc_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (tick) begin
                        acc_d = '0;
                        if (trig) state_d = StAttack;
                    end
                end
                StAttack: begin
                    if (tick) begin
                        if (!trig) begin
                            state_d = StRelease;
                        end else if (att_done) begin
                            acc_d   = AccMax;
                            state_d = StDecay;
                        end else begin
                            acc_d = att_sum[ACC_W-1:0];
                        end
                    end
                end
                StDecay: begin
                    if (tick) begin
                        if (!trig) begin
                            state_d = StRelease;
                        end else if (dec_done) begin
                            acc_d   = s_tgt;
                            state_d = StSustain;
                        end else begin
                            acc_d = dec_diff[ACC_W-1:0];
                        end
                    end
                end
                StSustain: begin
                    if (tick) begin
                        acc_d = s_tgt;
                        if (!trig) state_d = StRelease;
                    end
                end
                StRelease: begin
                    if (tick) begin
                        if (trig) begin
                            state_d = StAttack;
                        end else if (rel_done) begin
                            acc_d   = '0;
                            state_d = StIdle;
                        end else begin
                            acc_d = rel_diff[ACC_W-1:0];
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    acc_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        env    = acc_q[ACC_W-1 -: 8];
        active = (state_q != StIdle);
    end

endmodule

// File: tb/tb_adsr_env.sv
// Scoreboarded bench for adsr_env with a 4-cycle envelope tick.
module tb_adsr_env;

    logic       clk = 1'b0;
    logic       arstn;
    logic [7:0] ai, di, s, ri;
    logic       trig, progn;
    logic [7:0] env;
    logic       active;

    int n_chk  = 0;
    int n_fail = 0;

    string       name_q[$];
    logic [27:0] exp_q[$];

    always #5 clk = ~clk;

    adsr_env #(
        .PRESCALE (4),
        .ACC_W    (16)
    ) dut (
        .clk     (clk),
        .arstn   (arstn),
        .adsr_ai (ai),
        .adsr_di (di),
        .adsr_s  (s),
        .adsr_ri (ri),
        .trig    (trig),
        .progn   (progn),
        .env     (env),
        .active  (active)
    );

    // Monitor: drains every pending expectation on the falling edge.
    always @(negedge clk) begin
        logic [27:0] e_v, a_v;
        logic [2:0]  st;
        string       nm;
        while (exp_q.size() > 0) begin
            e_v = exp_q.pop_front();
            nm  = name_q.pop_front();
            st  = dut.state_q;
            a_v = {st, dut.acc_q, env, active};
            n_chk++;
            if (a_v !== e_v) begin
                n_fail++;
                $display("FAIL %s: got st=%0d acc=%h env=%h act=%b, want st=%0d acc=%h env=%h act=%b",
                         nm, a_v[27:25], a_v[24:9], a_v[8:1], a_v[0],
                         e_v[27:25], e_v[24:9], e_v[8:1], e_v[0]);
            end
        end
    end

    task automatic expect_now(input string nm, input logic [2:0] st, input logic [15:0] acc,
                              input logic [7:0] e, input logic a);
        name_q.push_back(nm);
        exp_q.push_back({st, acc, e, a});
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        int c;
        for (int k = 0; k < n; k++) begin
            c = 0;
            do begin
                @(negedge clk);
                c++;
            end while (!dut.tick && c < 20);
            if (!dut.tick) begin
                n_chk++;
                n_fail++;
                $display("FAIL tick_timeout: got no tick in %0d cycles, want one within 20", c);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Release reset and measure how many clocks pass before the first tick.
    task automatic release_reset();
        int c;
        @(negedge clk);
        arstn = 1'b1;
        c = 0;
        do begin
            @(posedge clk);
            c++;
            @(negedge clk);
        end while (!dut.tick && c < 20);
        n_chk++;
        if (c < 4 || !dut.tick) begin
            n_fail++;
            $display("FAIL first_tick: got tick after %0d clk (seen=%b), want >= 4 clk", c, dut.tick);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, want completion before 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        arstn = 1'b0; progn = 1'b0; trig = 1'b0;
        ai = 8'h00; di = 8'h00; s = 8'h00; ri = 8'h00;
        repeat (3) @(negedge clk);
        expect_now("reset", 3'd0, 16'h0000, 8'h00, 1'b0);
        progn = 1'b1;
        release_reset();

        // Full attack / decay / sustain / instant release.
        ai = 8'hFF; di = 8'h10; s = 8'h80; ri = 8'h00; trig = 1'b1;
        wait_ticks(1);    expect_now("idle_to_attack", 3'd1, 16'h0000, 8'h00, 1'b1);
        wait_ticks(1);    expect_now("attack_step1", 3'd1, 16'h00FF, 8'h00, 1'b1);
        wait_ticks(255);  expect_now("attack_256", 3'd1, 16'hFF00, 8'hFF, 1'b1);
        wait_ticks(1);    expect_now("attack_peak", 3'd2, 16'hFFFF, 8'hFF, 1'b1);
        wait_ticks(2047); expect_now("decay_2047", 3'd2, 16'h800F, 8'h80, 1'b1);
        wait_ticks(1);    expect_now("decay_to_sustain", 3'd3, 16'h8000, 8'h80, 1'b1);
        s = 8'h40;
        wait_ticks(1);    expect_now("sustain_track", 3'd3, 16'h4000, 8'h40, 1'b1);
        trig = 1'b0;
        wait_ticks(1);    expect_now("sustain_to_release", 3'd4, 16'h4000, 8'h40, 1'b1);
        wait_ticks(1);    expect_now("release_instant", 3'd0, 16'h0000, 8'h00, 1'b0);

        // Instant attack/decay, slow release, retrigger from the current level.
        s = 8'h80; ai = 8'h00; di = 8'h00; trig = 1'b1;
        wait_ticks(1);    expect_now("idle_to_attack2", 3'd1, 16'h0000, 8'h00, 1'b1);
        wait_ticks(1);    expect_now("attack_instant", 3'd2, 16'hFFFF, 8'hFF, 1'b1);
        wait_ticks(1);    expect_now("decay_instant", 3'd3, 16'h8000, 8'h80, 1'b1);
        ri = 8'h01; trig = 1'b0;
        wait_ticks(1);    expect_now("release_enter", 3'd4, 16'h8000, 8'h80, 1'b1);
        wait_ticks(16);   expect_now("release_16", 3'd4, 16'h7FF0, 8'h7F, 1'b1);
        trig = 1'b1; ai = 8'h10;
        wait_ticks(1);    expect_now("retrigger_keeps_acc", 3'd1, 16'h7FF0, 8'h7F, 1'b1);
        wait_ticks(1);    expect_now("attack_from_acc", 3'd1, 16'h8000, 8'h80, 1'b1);

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #3;
        arstn = 1'b0;
        expect_now("async_reset", 3'd0, 16'h0000, 8'h00, 1'b0);
        trig = 1'b0; ai = 8'hFF;
        release_reset();

        // Mute via progn during an attack.
        trig = 1'b1;
        wait_ticks(1);    expect_now("idle_to_attack3", 3'd1, 16'h0000, 8'h00, 1'b1);
        wait_ticks(64);   expect_now("attack_64", 3'd1, 16'h3FC0, 8'h3F, 1'b1);
        progn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_now("progn_mute", 3'd0, 16'h0000, 8'h00, 1'b0);
        repeat (12) @(negedge clk);
        #1;
        expect_now("progn_hold", 3'd0, 16'h0000, 8'h00, 1'b0);
        progn = 1'b1;
        wait_ticks(1);    expect_now("progn_resume", 3'd1, 16'h0000, 8'h00, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
